// File: rtl/lc3_mem_pkg.sv
// Shared types and defaults for the LC3 memory responder.
package lc3_mem_pkg;

  localparam int WORD_W         = 16;
  localparam int DEF_DEPTH_LOG2 = 10;
  localparam int DEF_I_LAT      = 1;
  localparam int DEF_D_LAT      = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } port_state_e;

endpackage

// File: rtl/lc3_mem_port_fsm.sv
// One request port: latches the request, counts LAT cycles, then strobes a
// single read or write and holds complete while the request stays unchanged.
module lc3_mem_port_fsm
  import lc3_mem_pkg::*;
#(
  parameter int LAT    = 1,
  parameter int ADDR_W = WORD_W,
  parameter int DATA_W = WORD_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              is_rd,
  output logic              complete,
  output logic              rd_strobe,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] lat_addr,
  output logic [DATA_W-1:0] lat_data
);

  localparam int              CNT_W    = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

  port_state_e      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             lat_rd;
  logic             capture;
  logic             changed;

  assign changed  = (addr != lat_addr) || (wr_data != lat_data) || (is_rd != lat_rd);
  assign complete = (state == DONE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Request copy is pure data; it is only consulted once capture has run.
  always_ff @(posedge clock) begin
    if (capture) begin
      lat_addr <= addr;
      lat_data <= wr_data;
      lat_rd   <= is_rd;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    rd_strobe = 1'b0;
    wr_strobe = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = WAIT;
          cnt_nxt   = CNT_LOAD;
          capture   = 1'b1;
        end
      end
      WAIT: begin
        if (!req) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (changed) begin
          cnt_nxt   = CNT_LOAD;
          capture   = 1'b1;
        end else if (cnt == '0) begin
          state_nxt = DONE;
          rd_strobe = lat_rd;
          wr_strobe = !lat_rd;
        end else begin
          cnt_nxt   = cnt - CNT_W'(1);
        end
      end
      DONE: begin
        if (!req) begin
          state_nxt = IDLE;
        end else if (changed) begin
          // Redirect while complete: restart the latency on the new request.
          state_nxt = WAIT;
          cnt_nxt   = CNT_LOAD;
          capture   = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/lc3_mem_responder.sv
// Memory responder for the LC3 core: one shared word array serving an
// instruction fetch port, a data port and a backdoor preload port.
module lc3_mem_responder
  import lc3_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int I_LAT      = DEF_I_LAT,
  parameter int D_LAT      = DEF_D_LAT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WORD_W-1:0] pc,
  input  logic              instrmem_rd,
  output logic [WORD_W-1:0] Instr_dout,
  output logic              complete_instr,
  input  logic              Data_en,
  input  logic [WORD_W-1:0] Data_addr,
  input  logic              Data_rd,
  input  logic [WORD_W-1:0] Data_din,
  output logic [WORD_W-1:0] Data_dout,
  output logic              complete_data,
  input  logic              load_en,
  input  logic [WORD_W-1:0] load_addr,
  input  logic [WORD_W-1:0] load_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WORD_W-1:0] mem [DEPTH];

  logic              i_rd, i_wr;
  logic [WORD_W-1:0] i_lat_addr, i_lat_data;
  logic              d_rd, d_wr;
  logic [WORD_W-1:0] d_lat_addr, d_lat_data;

  logic [DEPTH_LOG2-1:0] i_idx, d_idx, ld_idx;
  logic                  unused_bits;

  lc3_mem_port_fsm #(.LAT(I_LAT), .ADDR_W(WORD_W), .DATA_W(WORD_W)) u_instr_port (
    .clock     (clock),
    .reset     (reset),
    .req       (instrmem_rd),
    .addr      (pc),
    .wr_data   ('0),
    .is_rd     (1'b1),
    .complete  (complete_instr),
    .rd_strobe (i_rd),
    .wr_strobe (i_wr),
    .lat_addr  (i_lat_addr),
    .lat_data  (i_lat_data)
  );

  lc3_mem_port_fsm #(.LAT(D_LAT), .ADDR_W(WORD_W), .DATA_W(WORD_W)) u_data_port (
    .clock     (clock),
    .reset     (reset),
    .req       (Data_en),
    .addr      (Data_addr),
    .wr_data   (Data_din),
    .is_rd     (Data_rd),
    .complete  (complete_data),
    .rd_strobe (d_rd),
    .wr_strobe (d_wr),
    .lat_addr  (d_lat_addr),
    .lat_data  (d_lat_data)
  );

  // Upper address bits alias onto the array.
  assign i_idx  = i_lat_addr[DEPTH_LOG2-1:0];
  assign d_idx  = d_lat_addr[DEPTH_LOG2-1:0];
  assign ld_idx = load_addr[DEPTH_LOG2-1:0];

  assign unused_bits = ^{i_wr, i_lat_data, i_lat_addr, d_lat_addr, load_addr};

  // Later assignment wins: a data write commit overrides a same-word preload.
  always_ff @(posedge clock) begin
    if (load_en) mem[ld_idx] <= load_data;
    if (d_wr)    mem[d_idx]  <= d_lat_data;
  end

  // Reads sample the array before this edge's writes land.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      Instr_dout <= '0;
      Data_dout  <= '0;
    end else begin
      if (i_rd) Instr_dout <= mem[i_idx];
      if (d_rd) Data_dout  <= mem[d_idx];
    end
  end

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed bench for lc3_mem_responder with a reference memory and
// per-port expected-result queues.
module tb_lc3_mem_responder;

  localparam int DL    = 10;
  localparam int I_LAT = 1;
  localparam int D_LAT = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pc = '0;
  logic        instrmem_rd = 1'b0;
  logic [15:0] Instr_dout;
  logic        complete_instr;
  logic        Data_en = 1'b0;
  logic [15:0] Data_addr = '0;
  logic        Data_rd = 1'b0;
  logic [15:0] Data_din = '0;
  logic [15:0] Data_dout;
  logic        complete_data;
  logic        load_en = 1'b0;
  logic [15:0] load_addr = '0;
  logic [15:0] load_data = '0;

  lc3_mem_responder #(.DEPTH_LOG2(DL), .I_LAT(I_LAT), .D_LAT(D_LAT)) dut (
    .clock          (clock),
    .reset          (reset),
    .pc             (pc),
    .instrmem_rd    (instrmem_rd),
    .Instr_dout     (Instr_dout),
    .complete_instr (complete_instr),
    .Data_en        (Data_en),
    .Data_addr      (Data_addr),
    .Data_rd        (Data_rd),
    .Data_din       (Data_din),
    .Data_dout      (Data_dout),
    .complete_data  (complete_data),
    .load_en        (load_en),
    .load_addr      (load_addr),
    .load_data      (load_data)
  );

  always #5 clock = ~clock;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] model [1024];
  logic [15:0] iq[$];
  logic [15:0] dq[$];
  logic [15:0] i_dout_model = '0;
  logic [15:0] d_dout_model = '0;
  logic [15:0] exp_v;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en = 1'b0;
    model[a[DL-1:0]] = d;
  endtask

  task automatic fetch(input logic [15:0] a, input int hold);
    pc          = a;
    instrmem_rd = 1'b1;
    iq.push_back(model[a[DL-1:0]]);
    for (int c = 1; c <= I_LAT + 1 + hold; c++) begin
      tick();
      if (c <= I_LAT) chk("i_busy", 16'(complete_instr), 16'd0);
      else            chk("i_complete", 16'(complete_instr), 16'd1);
      if (c == I_LAT + 1) begin
        i_dout_model = iq.pop_front();
        chk("i_dout", Instr_dout, i_dout_model);
      end
    end
  endtask

  task automatic data_req(input logic rd, input logic [15:0] a, input logic [15:0] din,
                          input int hold, input int ld_cyc,
                          input logic [15:0] ld_a, input logic [15:0] ld_d);
    Data_en   = 1'b1;
    Data_rd   = rd;
    Data_addr = a;
    Data_din  = din;
    if (rd) dq.push_back(model[a[DL-1:0]]);
    else    dq.push_back(d_dout_model);
    for (int c = 1; c <= D_LAT + 1 + hold; c++) begin
      load_en   = (c == ld_cyc);
      load_addr = ld_a;
      load_data = ld_d;
      tick();
      load_en = 1'b0;
      if (c == ld_cyc) model[ld_a[DL-1:0]] = ld_d;
      if (c == D_LAT + 1 && !rd) model[a[DL-1:0]] = din;
      if (c <= D_LAT) chk("d_busy", 16'(complete_data), 16'd0);
      else            chk("d_complete", 16'(complete_data), 16'd1);
      if (c == D_LAT + 1) begin
        d_dout_model = dq.pop_front();
        chk("d_dout", Data_dout, d_dout_model);
      end
    end
  endtask

  task automatic i_release();
    instrmem_rd = 1'b0;
    tick();
    chk("i_drop", 16'(complete_instr), 16'd0);
    chk("i_keep", Instr_dout, i_dout_model);
  endtask

  task automatic d_release();
    Data_en = 1'b0;
    tick();
    chk("d_drop", 16'(complete_data), 16'd0);
    chk("d_keep", Data_dout, d_dout_model);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 reset = 1'b0;
    tick();
    tick();
    chk("rst_cinstr", 16'(complete_instr), 16'd0);
    chk("rst_cdata", 16'(complete_data), 16'd0);
    chk("rst_idout", Instr_dout, 16'h0000);
    chk("rst_ddout", Data_dout, 16'h0000);
    reset = 1'b1;
    tick();

    preload(16'h0040, 16'h1234);
    preload(16'h0050, 16'h5A5A);
    preload(16'h0200, 16'h0000);
    preload(16'h0100, 16'h0000);
    preload(16'h0300, 16'h1111);

    // Fetch, then redirect while complete.
    fetch(16'h0040, 3);
    fetch(16'h0050, 2);
    i_release();

    // Write then read back.
    data_req(1'b0, 16'h0100, 16'hBEEF, 2, 0, 16'h0000, 16'h0000);
    d_release();
    data_req(1'b1, 16'h0100, 16'h0000, 1, 0, 16'h0000, 16'h0000);
    d_release();

    // Single commit: a preload after completion must survive the held request.
    data_req(1'b0, 16'h0100, 16'hCAFE, 3, D_LAT + 2, 16'h0100, 16'h7777);
    d_release();
    data_req(1'b1, 16'h0100, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    d_release();

    // Same-edge preload vs data write, then aliased read.
    data_req(1'b0, 16'h0100, 16'hBEEF, 1, D_LAT + 1, 16'h0100, 16'h0BAD);
    d_release();
    data_req(1'b1, 16'h0500, 16'h0000, 1, 0, 16'h0000, 16'h0000);
    d_release();

    // Same-edge preload vs read completion.
    data_req(1'b1, 16'h0050, 16'h0000, 0, D_LAT + 1, 16'h0050, 16'h6666);
    d_release();
    data_req(1'b1, 16'h0050, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    d_release();

    // Write abandoned in WAIT.
    Data_en   = 1'b1;
    Data_rd   = 1'b0;
    Data_addr = 16'h0200;
    Data_din  = 16'hAAAA;
    for (int c = 1; c <= D_LAT; c++) begin
      tick();
      chk("abort_wait", 16'(complete_data), 16'd0);
    end
    Data_en = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk("abort_idle", 16'(complete_data), 16'd0);
    end
    data_req(1'b1, 16'h0200, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    d_release();

    // Data write commit and instruction read completion on the same edge.
    Data_en   = 1'b1;
    Data_rd   = 1'b0;
    Data_addr = 16'h0300;
    Data_din  = 16'h9999;
    dq.push_back(d_dout_model);
    for (int c = 1; c <= D_LAT - I_LAT; c++) begin
      tick();
      chk("coll_dbusy", 16'(complete_data), 16'd0);
    end
    pc          = 16'h0300;
    instrmem_rd = 1'b1;
    iq.push_back(model[10'h300]);
    for (int c = 1; c <= I_LAT; c++) begin
      tick();
      chk("coll_ibusy", 16'(complete_instr), 16'd0);
    end
    tick();
    model[10'h300] = 16'h9999;
    chk("coll_icomp", 16'(complete_instr), 16'd1);
    chk("coll_dcomp", 16'(complete_data), 16'd1);
    i_dout_model = iq.pop_front();
    chk("coll_idout", Instr_dout, i_dout_model);
    d_dout_model = dq.pop_front();
    chk("coll_ddout", Data_dout, d_dout_model);
    i_release();
    d_release();
    fetch(16'h0300, 0);
    i_release();

    // Reset while both ports are waiting.
    data_req(1'b1, 16'h0100, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    d_release();
    pc          = 16'h0040;
    instrmem_rd = 1'b1;
    Data_en     = 1'b1;
    Data_rd     = 1'b0;
    Data_addr   = 16'h0040;
    Data_din    = 16'hDEAD;
    tick();
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_cinstr", 16'(complete_instr), 16'd0);
    chk("mid_rst_cdata", 16'(complete_data), 16'd0);
    chk("mid_rst_idout", Instr_dout, 16'h0000);
    chk("mid_rst_ddout", Data_dout, 16'h0000);
    i_dout_model = '0;
    d_dout_model = '0;
    instrmem_rd  = 1'b0;
    Data_en      = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    fetch(16'h0040, 1);
    i_release();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
